// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide sequencer owning HI/LO.
// The result is computed when the command is accepted and held as a pending
// value. It is committed to HI/LO only when the latency countdown expires,
// so HI/LO never show a partial result. The hazard unit is held off through
// MDU_o_stallReq while an operation is in flight.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDU_i_start,
    input  logic [2:0]  MDU_i_op,
    input  logic [31:0] MDU_i_Operand1,
    input  logic [31:0] MDU_i_Operand2,
    output logic [31:0] MDU_o_HI,
    output logic [31:0] MDU_o_LO,
    output logic        MDU_o_busy,
    output logic        MDU_o_stallReq
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) > 0) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [31:0]        hi_r, hi_nxt_s;
    logic [31:0]        lo_r, lo_nxt_s;
    logic [31:0]        pend_hi_r, pend_hi_nxt_s;
    logic [31:0]        pend_lo_r, pend_lo_nxt_s;
    logic               pend_valid_r, pend_valid_nxt_s;
    logic               busy_r;

    // Arithmetic datapath operands and results.
    logic signed [31:0] op1_sgn_s;
    logic signed [31:0] op2_sgn_s;
    logic signed [31:0] sdivisor_s;
    logic [31:0]        udivisor_s;
    logic signed [63:0] smul_s;
    logic [63:0]        umul_s;
    logic signed [31:0] squot_s;
    logic signed [31:0] srem_s;
    logic [31:0]        uquot_s;
    logic [31:0]        urem_s;
    logic               div_zero_s;
    logic               is_mdu_op_s;

    assign op1_sgn_s  = MDU_i_Operand1;
    assign op2_sgn_s  = MDU_i_Operand2;
    assign div_zero_s = (MDU_i_Operand2 == 32'd0);
    // A zero divisor is replaced by one only to keep the divider well defined;
    // that result is never committed because pend_valid stays low.
    assign sdivisor_s = div_zero_s ? 32'sd1 : op2_sgn_s;
    assign udivisor_s = div_zero_s ? 32'd1 : MDU_i_Operand2;

    assign smul_s  = op1_sgn_s * op2_sgn_s;
    assign umul_s  = {32'd0, MDU_i_Operand1} * {32'd0, MDU_i_Operand2};
    assign squot_s = op1_sgn_s / sdivisor_s;
    assign srem_s  = op1_sgn_s % sdivisor_s;
    assign uquot_s = MDU_i_Operand1 / udivisor_s;
    assign urem_s  = MDU_i_Operand1 % udivisor_s;

    assign is_mdu_op_s = (MDU_i_op >= OP_MULT) && (MDU_i_op <= OP_DIVU);

    assign MDU_o_HI       = hi_r;
    assign MDU_o_LO       = lo_r;
    assign MDU_o_busy     = busy_r;
    assign MDU_o_stallReq = busy_r | (MDU_i_start & is_mdu_op_s);

    // Next-state logic: accept commands in IDLE, count down and commit in RUN.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        hi_nxt_s         = hi_r;
        lo_nxt_s         = lo_r;
        pend_hi_nxt_s    = pend_hi_r;
        pend_lo_nxt_s    = pend_lo_r;
        pend_valid_nxt_s = pend_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (MDU_i_start) begin
                    case (MDU_i_op)
                        OP_MULT: begin
                            pend_hi_nxt_s    = smul_s[63:32];
                            pend_lo_nxt_s    = smul_s[31:0];
                            pend_valid_nxt_s = 1'b1;
                            cnt_nxt_s        = CNT_W'(MULT_CYCLES - 1);
                            state_nxt_s      = ST_RUN;
                        end
                        OP_MULTU: begin
                            pend_hi_nxt_s    = umul_s[63:32];
                            pend_lo_nxt_s    = umul_s[31:0];
                            pend_valid_nxt_s = 1'b1;
                            cnt_nxt_s        = CNT_W'(MULT_CYCLES - 1);
                            state_nxt_s      = ST_RUN;
                        end
                        OP_DIV: begin
                            pend_hi_nxt_s    = srem_s;
                            pend_lo_nxt_s    = squot_s;
                            pend_valid_nxt_s = ~div_zero_s;
                            cnt_nxt_s        = CNT_W'(DIV_CYCLES - 1);
                            state_nxt_s      = ST_RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_nxt_s    = urem_s;
                            pend_lo_nxt_s    = uquot_s;
                            pend_valid_nxt_s = ~div_zero_s;
                            cnt_nxt_s        = CNT_W'(DIV_CYCLES - 1);
                            state_nxt_s      = ST_RUN;
                        end
                        OP_MTHI: begin
                            hi_nxt_s = MDU_i_Operand1;
                        end
                        OP_MTLO: begin
                            lo_nxt_s = MDU_i_Operand1;
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Commands arriving while busy are dropped; stallReq holds them off.
                if (cnt_r == CNT_W'(0)) begin
                    if (pend_valid_r) begin
                        hi_nxt_s = pend_hi_r;
                        lo_nxt_s = pend_lo_r;
                    end else begin
                        hi_nxt_s = hi_r;
                        lo_nxt_s = lo_r;
                    end
                    pend_valid_nxt_s = 1'b0;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                pend_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            hi_r         <= 32'd0;
            lo_r         <= 32'd0;
            pend_hi_r    <= 32'd0;
            pend_lo_r    <= 32'd0;
            pend_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            hi_r         <= hi_nxt_s;
            lo_r         <= lo_nxt_s;
            pend_hi_r    <= pend_hi_nxt_s;
            pend_lo_r    <= pend_lo_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            busy_r       <= (state_nxt_s == ST_RUN);
        end
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide unit (MDU) sequencer for the pipelined MIPS core, sitting in EX beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from EX and owns the HI/LO registers.
- Models fixed multiply and divide latencies with a countdown and raises a stall request for the hazard unit while an operation is in flight.
- Results are computed behaviourally at start, held, and committed to HI/LO when the countdown completes.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10: busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MDU_i_start  input  1  command valid this cycle.
- MDU_i_op  input  3  command: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- MDU_i_Operand1  input  32  rs value.
- MDU_i_Operand2  input  32  rt value.
- MDU_o_HI  output  32  current HI register.
- MDU_o_LO  output  32  current LO register.
- MDU_o_busy  output  1  operation in flight.
- MDU_o_stallReq  output  1  combinational: busy OR (start AND op in 1..4).

Behaviour:
- Reset, checked at the clock edge with priority over all else:
  - HI=0, LO=0, busy=0, counter=0, pending result cleared.
  - Applies mid-operation: the in-flight result is discarded, HI/LO do not update.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter counts down).
- IDLE, start with op 1..4, sampled at edge T:
  - Latch the pending result: {HI,LO}.
  - counter=MULT_CYCLES-1 or DIV_CYCLES-1.
  - busy=1 from T.
- Arithmetic:
  - MULT: signed 32x32 -> 64-bit product; HI=upper 32, LO=lower 32.
  - MULTU: same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (Operand2=0): full busy duration runs; HI/LO unchanged at completion.
- RUN:
  - counter decrements each edge.
  - At the edge where counter==0: commit pending to HI/LO, busy->0, return to IDLE.
  - Net effect: result visible on MDU_o_HI/LO exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES), and busy is high for exactly N cycles.
- MTHI/MTLO in IDLE:
  - HI (resp. LO) = Operand1 at the next edge; no busy.
  - The other register is unchanged.
- Any start while busy (including MT*): ignored; the hazard unit must stall via stallReq.
- Back-to-back: a start in the cycle after busy falls is accepted normally.
- MDU_o_HI/LO never show partial results; they always reflect committed registers.
- Op 0 or 7 with start=1: no effect.

Test Plan:
- reset, then MULT 7 x -1956 (0xFFFFF85C) -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFCA84; HI/LO stay 0 during busy.
- MULTU 0xFFFFFFFF x 2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV -1956 / 11 -> busy 10 cycles, then LO=0xFFFFFF4F (-177), HI=0xFFFFFFF7 (-9).
- DIVU 1234567 / 7 -> LO=0x0002B0EE, HI=0x00000005.
- DIVU x / 0, then MTLO 0x12345678 issued while busy -> HI/LO unchanged after 10 cycles, MTLO ignored, stallReq high throughout.
- Start MULT, assert reset on cycle 3 -> HI=LO=0, busy=0 next edge, no later commit; MTHI 0xDEADBEEF in IDLE -> HI=0xDEADBEEF next cycle, busy stays 0.
